// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//   Serial bit-pattern detector with a run-time configurable pattern, length
//   and overlap mode (up to MAX_LEN bits). Bits arrive MSB-of-pattern first,
//   qualified by i_in_valid. A match produces a registered one-cycle pulse on
//   o_detected and bumps a saturating match counter.
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_reset_n       synchronous active-low reset
//   i_cfg_load      latch i_cfg_pattern/i_cfg_len/i_cfg_overlap, restart search
//   i_cfg_pattern   pattern; bit [len-1] is received first, bit [0] last
//   i_cfg_len       pattern length (0 disables, >MAX_LEN clamps to MAX_LEN)
//   i_cfg_overlap   1 = overlapping matches allowed
//   i_clear_count   synchronous clear of o_match_count (wins over a match)
//   i_in_valid      i_in carries a new stream bit this cycle
//   i_in            serial data bit
//   o_detected      one-cycle match pulse, registered
//   o_match_count   saturating count of matches
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0001_1010,
  parameter int                 RST_LEN     = 5,
  parameter bit                 RST_OVERLAP = 1'b0,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_clear_count,
  input  logic               i_in_valid,
  input  logic               i_in,
  output logic               o_detected,
  output logic [CNT_W-1:0]   o_match_count
);

  // Active configuration
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  // Stream state
  logic [MAX_LEN-1:0] r_history;
  logic [LEN_W-1:0]   r_fill;
  logic               r_detected;
  logic [CNT_W-1:0]   r_match_count;

  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_pat_eq;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_full;
  logic [LEN_W-1:0]   w_fill_sat;
  logic               w_accept;
  logic               w_match;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_cnt_max;

  // Candidate window including the bit arriving this cycle.
  assign w_cand = {r_history[MAX_LEN-2:0], i_in};

  // Only the low r_len bits take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (r_len > LEN_W'(gi));
  end

  assign w_pat_eq = (((w_cand ^ r_pattern) & w_mask) == '0);

  // One extra bit so fill+1 cannot wrap when MAX_LEN+1 is a power of two.
  assign w_fill_inc = {1'b0, r_fill} + (LEN_W + 1)'(1);
  assign w_full     = (w_fill_inc >= {1'b0, r_len});
  assign w_fill_sat = w_full ? r_len : w_fill_inc[LEN_W-1:0];

  // A config load in the same cycle swallows the data bit.
  assign w_accept = i_in_valid & ~i_cfg_load;
  assign w_match  = w_accept & (r_len != '0) & w_full & w_pat_eq;

  assign w_cfg_len = (i_cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_cfg_len;
  assign w_cnt_max = &r_match_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pattern     <= RST_PATTERN;
      r_len         <= LEN_W'(RST_LEN);
      r_overlap     <= RST_OVERLAP;
      r_history     <= '0;
      r_fill        <= '0;
      r_detected    <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_detected <= w_match;

      if (i_cfg_load) begin
        r_pattern <= i_cfg_pattern;
        r_len     <= w_cfg_len;
        r_overlap <= i_cfg_overlap;
        r_history <= '0;
        r_fill    <= '0;
      end else if (w_accept) begin
        r_history <= w_cand;
        // Non-overlap mode restarts the fill so the next match needs len
        // fresh bits; the history itself keeps shifting either way.
        if (w_match && !r_overlap) begin
          r_fill <= '0;
        end else begin
          r_fill <= w_fill_sat;
        end
      end

      if (i_clear_count) begin
        r_match_count <= '0;
      end else if (w_match && !w_cnt_max) begin
        r_match_count <= r_match_count + CNT_W'(1);
      end
    end
  end

  assign o_detected    = r_detected;
  assign o_match_count = r_match_count;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//   Directed-vector bench for seq_pattern_detector (MAX_LEN=8, CNT_W=2 so the
//   counter saturates at 3 within short sequences). Expected pulses are
//   hand-written per vector; the expected count follows those pulses.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clear_count;
  logic               in_valid;
  logic               in_bit;
  logic               detected;
  logic [CNT_W-1:0]   match_count;

  int n_cmp   = 0;
  int n_err   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN     (MAX_LEN),
    .CNT_W       (CNT_W),
    .RST_PATTERN (8'b0001_1010),
    .RST_LEN     (5),
    .RST_OVERLAP (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_cfg_load    (cfg_load),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_len     (cfg_len),
    .i_cfg_overlap (cfg_overlap),
    .i_clear_count (clear_count),
    .i_in_valid    (in_valid),
    .i_in          (in_bit),
    .o_detected    (detected),
    .o_match_count (match_count)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one bit; outputs are sampled 1 time unit after the accepting edge.
  task automatic send_bit(input logic b, input logic exp_det, input logic clr, input string tag);
    in_valid    = 1'b1;
    in_bit      = b;
    clear_count = clr;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    clear_count = 1'b0;
    if (clr) exp_cnt = 0;
    else if (exp_det && exp_cnt < CNT_MAX) exp_cnt++;
    $display("%s: in=%0b det=%0b cnt=%0d", tag, b, detected, match_count);
    chk_val({tag, " det"}, 32'(detected), 32'(exp_det));
    chk_val({tag, " cnt"}, 32'(match_count), 32'(exp_cnt));
  endtask

  // bits[n-1] is sent first; dets[i] is the expected pulse for that bit.
  task automatic run_seq(input logic [31:0] bits, input logic [31:0] dets, input int n, input string name);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i], dets[i], 1'b0, $sformatf("%s[%0d]", name, n - 1 - i));
    end
  endtask

  // Invalid cycles with in toggling: nothing may change.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      in_bit = ~in_bit;
      @(posedge clk);
      #1;
      $display("%s: idle det=%0b cnt=%0d", tag, detected, match_count);
      chk_val({tag, " idle det"}, 32'(detected), 32'd0);
      chk_val({tag, " idle cnt"}, 32'(match_count), 32'(exp_cnt));
    end
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ov, input logic vld, input logic b, input string tag);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    in_valid    = vld;
    in_bit      = b;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    $display("%s: load pat=%0h len=%0d ov=%0b det=%0b cnt=%0d", tag, pat, len, ov, detected, match_count);
    chk_val({tag, " load det"}, 32'(detected), 32'd0);
    chk_val({tag, " load cnt"}, 32'(match_count), 32'(exp_cnt));
  endtask

  task automatic do_clear(input string tag);
    clear_count = 1'b1;
    @(posedge clk);
    #1;
    clear_count = 1'b0;
    exp_cnt     = 0;
    $display("%s: clear cnt=%0d", tag, match_count);
    chk_val({tag, " clear cnt"}, 32'(match_count), 32'd0);
  endtask

  task automatic do_reset(input int n, input string tag);
    reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_cnt = 0;
    $display("%s: reset det=%0b cnt=%0d", tag, detected, match_count);
    chk_val({tag, " rst det"}, 32'(detected), 32'd0);
    chk_val({tag, " rst cnt"}, 32'(match_count), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    clear_count = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;

    // Reset defaults: 11010, non-overlap.
    do_reset(2, "rst");
    run_seq(32'b11010, 32'b00001, 5, "dflt");

    // 101, non-overlap: only the first match.
    do_clear("novl");
    load_cfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0, "novl");
    run_seq(32'b10101, 32'b00100, 5, "novl");

    // 101, overlap: trailing 1 is reused.
    do_clear("ovl");
    load_cfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0, "ovl");
    run_seq(32'b10101, 32'b00101, 5, "ovl");

    // Default pattern with two invalid cycles between bits.
    do_clear("gap");
    load_cfg(8'h1A, 4'd5, 1'b0, 1'b0, 1'b0, "gap");
    send_bit(1'b1, 1'b0, 1'b0, "gap[0]"); idle(2, "gap");
    send_bit(1'b1, 1'b0, 1'b0, "gap[1]"); idle(2, "gap");
    send_bit(1'b0, 1'b0, 1'b0, "gap[2]"); idle(2, "gap");
    send_bit(1'b1, 1'b0, 1'b0, "gap[3]"); idle(2, "gap");
    send_bit(1'b0, 1'b1, 1'b0, "gap[4]"); idle(2, "gap");

    // len=0 disables detection.
    load_cfg(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, "len0");
    for (int i = 0; i < 20; i++) begin
      send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, $sformatf("len0[%0d]", i));
    end

    // Bit presented together with cfg_load is discarded: without it the
    // following 7 bits cannot complete A5.
    load_cfg(8'hA5, 4'd8, 1'b0, 1'b1, 1'b1, "disc");
    run_seq(32'b0100101, 32'b0, 7, "disc");

    // Full-length pattern after stale bits: needs 8 new bits.
    load_cfg(8'h1A, 4'd5, 1'b0, 1'b0, 1'b0, "pre");
    run_seq(32'b111, 32'b000, 3, "pre");
    load_cfg(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, "len8");
    run_seq(32'b10100101, 32'b00000001, 8, "len8");

    // cfg_len above MAX_LEN clamps to MAX_LEN.
    load_cfg(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0, "clamp");
    run_seq(32'b10100101, 32'b00000001, 8, "clamp");

    // Saturation at 3, then clear beats a simultaneous match.
    do_clear("sat");
    load_cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, "sat");
    run_seq(32'b111111, 32'b111111, 6, "sat");
    send_bit(1'b1, 1'b1, 1'b1, "satclr");
    send_bit(1'b1, 1'b1, 1'b0, "satpost");

    // Reset mid-pattern discards progress.
    do_reset(1, "mid0");
    run_seq(32'b1101, 32'b0000, 4, "mid_pre");
    do_reset(1, "mid1");
    send_bit(1'b0, 1'b0, 1'b0, "mid_zero");
    run_seq(32'b11010, 32'b00001, 5, "mid_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
